otter_mem2_arbiter: RTL and testbench
=====================================

Name: otter_mem2_arbiter

Overview:
- Arbitrates data port 2 of OTTER_mem_byte between two requesters:
  - the CPU's data-access path (CU_FSM memRead2/memWrite, ALU_out address, rs2 data);
  - a secondary bus master (DMA/loader).
- The CPU has priority, but a starvation counter guarantees the secondary master forward progress by freezing the CPU FSM with cpu_hold.
- Sits between the CPU/programmer signals and the memory port-2 inputs; tags the 1-cycle read latency back to the correct owner.

Parameters:
- STARVE_LIMIT, 8, consecutive denied DMA-request cycles before cpu_hold asserts (1..255).
- CNT_W, $clog2(STARVE_LIMIT+1), starvation counter width (derived).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- cpu_rd  in  1  CPU read request (memRead2)
- cpu_wr  in  1  CPU write request (memWrite)
- cpu_addr  in  32  CPU byte address
- cpu_din  in  32  CPU write data
- cpu_size  in  2  CPU access size (ir[13:12])
- cpu_sign  in  1  CPU unsigned flag (ir[14])
- cpu_hold  out  1  freeze CU_FSM state this cycle
- cpu_rvalid  out  1  MEM_DOUT2 holds CPU read data this cycle
- dma_req  in  1  DMA access request, held until accepted
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  32  DMA byte address
- dma_din  in  32  DMA write data
- dma_size  in  2  DMA access size
- dma_sign  in  1  DMA unsigned flag
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  MEM_DOUT2 holds DMA read data this cycle
- mem_addr  out  32  to MEM_ADDR2
- mem_din  out  32  to MEM_DIN2
- mem_write  out  1  to MEM_WRITE2
- mem_read  out  1  to MEM_READ2
- mem_size  out  2  to MEM_SIZE
- mem_sign  out  1  to MEM_SIGN

Behaviour:
- Reset (RST=1 at posedge): state=NORMAL, starve_cnt=0, cpu_hold=0, cpu_rvalid=0, dma_rvalid=0. Combinational outputs follow the owner rules with registered state cleared.
- Owner selection (combinational, per cycle):
  - cpu_act = (cpu_rd|cpu_wr) & ~cpu_hold.
  - owner=CPU if cpu_act.
  - else owner=DMA if dma_req.
  - else none.
- dma_gnt = dma_req & ~cpu_act. A transfer is accepted in the cycle dma_gnt=1; the requester may change inputs on the next cycle.
- Memory mux:
  - owner CPU: mem_* = cpu_* (mem_read=cpu_rd, mem_write=cpu_wr).
  - owner DMA: mem_addr/din/size/sign = dma_*, mem_write=dma_we, mem_read=~dma_we.
  - none: mem_read=0, mem_write=0; addr/din/size/sign = CPU values.
- Read tagging (registered, latency 1):
  - cpu_rvalid <= cpu_act & cpu_rd.
  - dma_rvalid <= dma_gnt & ~dma_we.
  - Never both 1 in the same cycle.
- FSM, two states:
  - NORMAL: if dma_req & ~dma_gnt, starve_cnt++ (saturating). Else if dma_gnt, starve_cnt=0. Else starve_cnt holds. When starve_cnt reaches STARVE_LIMIT-1 and the DMA is denied again, go to HOLD next cycle.
  - HOLD: cpu_hold=1 (registered state decode); CPU requests are masked, so the DMA wins. Exit to NORMAL the cycle after dma_gnt=1 (one DMA transfer per hold); starve_cnt=0 on exit. If dma_req drops while in HOLD, return to NORMAL next cycle and clear starve_cnt.
- cpu_hold is a state decode only; it never depends combinationally on inputs.
- The CPU must not change cpu_* or advance its FSM while cpu_hold=1; its request is re-presented on release.
- If cpu_rd and cpu_wr are both 1, write takes effect and cpu_rvalid still follows cpu_rd. Protocol error; flagged by a simulation assertion only.
- Reset mid-operation: pending rvalid is dropped, hold releases, and the counter clears in the same edge.

Decomposition:
- Shared package otter_pkg holds:
  - typedef enum logic {ARB_NORMAL, ARB_HOLD} arb_state_t;
  - typedef struct mem2_req_t {addr, din, size, sign, rd, wr}.
- One natural sub-module: starve_counter (saturating counter with clear, CNT_W wide, terminal flag). The port mux stays inline.

Test Plan:
- Reset with all requests 0: cpu_hold=0, dma_gnt=0, mem_read=0, mem_write=0, both rvalid=0 on the first cycle after RST deasserts.
- CPU read only: cpu_rd=1, addr 0x0000_6000, size 2 → mem_addr=0x6000, mem_read=1 same cycle; cpu_rvalid=1 the next cycle, dma_rvalid=0.
- Collision: cpu_wr=1 and dma_req=1 (read, addr 0x100) in the same cycle → mem_write=1 with the CPU address, dma_gnt=0, starve_cnt=1. When the CPU goes idle the next cycle: dma_gnt=1, mem_read=1, addr 0x100; dma_rvalid=1 one cycle later.
- Starvation, STARVE_LIMIT=8: CPU requests continuously while dma_req is held → after 8 denied cycles cpu_hold=1. In that cycle dma_gnt=1 despite cpu_rd=1. The next cycle cpu_hold=0 and starve_cnt=0.
- Hold abort: enter HOLD, then drop dma_req → the next cycle state=NORMAL, cpu_hold=0, no memory access issued.
- RST asserted while in HOLD with dma_rvalid pending → the next cycle cpu_hold=0, dma_rvalid=0, starve_cnt=0.

Source files
------------

// File: rtl/otter_pkg.sv
// Shared types for the OTTER memory port-2 arbiter.
package otter_pkg;

    typedef enum logic {ARB_NORMAL, ARB_HOLD} arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
        logic        rd;
        logic        wr;
    } mem2_req_t;

endpackage

// File: rtl/otter_mem2_arbiter_starve_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag.
module starve_counter #(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != CNT_W'(LIMIT)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/otter_mem2_arbiter.sv
// Port-2 arbiter: CPU has priority, starvation counter forces a DMA slot via cpu_hold.
module otter_mem2_arbiter
    import otter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic        cpu_hold,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_din,
    input  logic [1:0]  dma_size,
    input  logic        dma_sign,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  mem_size,
    output logic        mem_sign
);

    arb_state_t       state_q, state_d;
    logic             cpu_rvalid_q, dma_rvalid_q;
    logic             cpu_act, denied;
    logic             cnt_inc, cnt_clr, cnt_term;
    logic [CNT_W-1:0] starve_cnt;
    mem2_req_t        cpu_req_s, dma_req_s, mem_req_s;

    assign cpu_hold = (state_q == ARB_HOLD);
    assign cpu_act  = (cpu_rd | cpu_wr) & ~cpu_hold;
    assign dma_gnt  = dma_req & ~cpu_act;
    assign denied   = dma_req & ~dma_gnt;

    always_comb begin
        cpu_req_s = '{addr: cpu_addr, din: cpu_din, size: cpu_size,
                      sign: cpu_sign, rd: cpu_rd, wr: cpu_wr};
        dma_req_s = '{addr: dma_addr, din: dma_din, size: dma_size,
                      sign: dma_sign, rd: ~dma_we, wr: dma_we};
        mem_req_s = cpu_req_s;
        if (!cpu_act) begin
            if (dma_req) begin
                mem_req_s = dma_req_s;
            end else begin
                mem_req_s.rd = 1'b0;
                mem_req_s.wr = 1'b0;
            end
        end
    end

    assign mem_addr  = mem_req_s.addr;
    assign mem_din   = mem_req_s.din;
    assign mem_size  = mem_req_s.size;
    assign mem_sign  = mem_req_s.sign;
    assign mem_read  = mem_req_s.rd;
    assign mem_write = mem_req_s.wr;

    // HOLD always lasts one cycle: either the DMA is granted or it has withdrawn.
    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ARB_NORMAL: begin
                if (denied) begin
                    cnt_inc = 1'b1;
                    if (cnt_term)
                        state_d = ARB_HOLD;
                end else if (dma_gnt) begin
                    cnt_clr = 1'b1;
                end
            end
            ARB_HOLD: begin
                state_d = ARB_NORMAL;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ARB_NORMAL;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ARB_NORMAL;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= cpu_act & cpu_rd;
            dma_rvalid_q <= dma_gnt & ~dma_we;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve (
        .clk_i  (CLK),
        .rst_i  (RST),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .cnt_o  (starve_cnt),
        .term_o (cnt_term)
    );

    a_no_rd_wr: assert property (@(posedge CLK) disable iff (RST) !(cpu_rd && cpu_wr));
    a_one_rvalid: assert property (@(posedge CLK) !(cpu_rvalid && dma_rvalid));

endmodule

// File: tb/tb_otter_mem2_arbiter.sv
// Directed self-checking bench for otter_mem2_arbiter with STARVE_LIMIT = 8.
module tb_otter_mem2_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_rd, cpu_wr, cpu_sign;
    logic [31:0] cpu_addr, cpu_din;
    logic [1:0]  cpu_size;
    logic        cpu_hold, cpu_rvalid;
    logic        dma_req, dma_we, dma_sign;
    logic [31:0] dma_addr, dma_din;
    logic [1:0]  dma_size;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_din;
    logic        mem_write, mem_read, mem_sign;
    logic [1:0]  mem_size;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    otter_mem2_arbiter #(.STARVE_LIMIT(8)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_hold(cpu_hold), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_size(dma_size), .dma_sign(dma_sign), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_write(mem_write), .mem_read(mem_read),
        .mem_size(mem_size), .mem_sign(mem_sign)
    );

    wire [3:0] starve_cnt = dut.starve_cnt;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 32'h1234; cpu_din = 32'h0; cpu_size = 2'd0; cpu_sign = 0;
        dma_req = 0; dma_we = 0; dma_addr = 32'h0; dma_din = 32'h0; dma_size = 2'd0; dma_sign = 0;
        tick; tick;
        RST = 1'b0;
        #1;
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got %b want 0", cpu_hold); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", dma_gnt); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_rw got %b want 00", {mem_read, mem_write}); end
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
        checks++; if (mem_addr !== 32'h1234) begin errors++; $display("FAIL idle_addr got %h want 00001234", mem_addr); end
        checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", starve_cnt); end
    endtask

    task automatic test_cpu_read;
        tick;
        cpu_rd = 1; cpu_addr = 32'h0000_6000; cpu_size = 2'd2; cpu_sign = 1;
        #1;
        checks++; if (mem_addr !== 32'h6000) begin errors++; $display("FAIL cpurd_addr got %h want 00006000", mem_addr); end
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL cpurd_rw got %b want 10", {mem_read, mem_write}); end
        checks++; if ({mem_size, mem_sign} !== 3'b101) begin errors++; $display("FAIL cpurd_size got %b want 101", {mem_size, mem_sign}); end
        tick;
        cpu_rd = 0;
        #1;
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b10) begin errors++; $display("FAIL cpurd_rvalid got %b want 10", {cpu_rvalid, dma_rvalid}); end
    endtask

    task automatic test_collision;
        tick;
        cpu_wr = 1; cpu_addr = 32'h200; cpu_din = 32'hDEAD_BEEF; cpu_size = 2'd2; cpu_sign = 0;
        dma_req = 1; dma_we = 0; dma_addr = 32'h100; dma_size = 2'd1; dma_sign = 1;
        #1;
        checks++; if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL coll_rw got %b want 01", {mem_read, mem_write}); end
        checks++; if (mem_addr !== 32'h200 || mem_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_cpu got %h/%h want 00000200/deadbeef", mem_addr, mem_din); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL coll_gnt got %b want 0", dma_gnt); end
        tick;
        cpu_wr = 0;
        #1;
        checks++; if (starve_cnt !== 4'd1) begin errors++; $display("FAIL coll_cnt got %0d want 1", starve_cnt); end
        checks++; if (dma_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL coll_dma got gnt=%b rd=%b wr=%b want 1 1 0", dma_gnt, mem_read, mem_write); end
        checks++; if (mem_addr !== 32'h100 || mem_size !== 2'd1 || mem_sign !== 1'b1) begin errors++; $display("FAIL coll_dma_addr got %h %0d %b want 00000100 1 1", mem_addr, mem_size, mem_sign); end
        tick;
        dma_req = 0;
        #1;
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b01) begin errors++; $display("FAIL coll_rvalid got %b want 01", {cpu_rvalid, dma_rvalid}); end
        checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL coll_cnt_clr got %0d want 0", starve_cnt); end
    endtask

    task automatic test_starvation;
        tick;
        cpu_rd = 1; cpu_addr = 32'h40;
        dma_req = 1; dma_we = 1; dma_addr = 32'h300; dma_din = 32'h55;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (cpu_hold !== 1'b0 || dma_gnt !== 1'b0 || starve_cnt !== 4'(i)) begin errors++; $display("FAIL starve_%0d got hold=%b gnt=%b cnt=%0d want 0 0 %0d", i, cpu_hold, dma_gnt, starve_cnt, i); end
            tick;
        end
        checks++; if (cpu_hold !== 1'b1 || dma_gnt !== 1'b1) begin errors++; $display("FAIL starve_hold got hold=%b gnt=%b want 1 1", cpu_hold, dma_gnt); end
        checks++; if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 32'h300 || mem_din !== 32'h55) begin errors++; $display("FAIL starve_mux got rw=%b %h %h want 01 00000300 00000055", {mem_read, mem_write}, mem_addr, mem_din); end
        tick;
        dma_req = 0;
        #1;
        checks++; if (cpu_hold !== 1'b0 || starve_cnt !== 4'd0) begin errors++; $display("FAIL starve_exit got hold=%b cnt=%0d want 0 0", cpu_hold, starve_cnt); end
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL starve_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
        checks++; if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 32'h40) begin errors++; $display("FAIL starve_cpu_back got rw=%b %h want 10 00000040", {mem_read, mem_write}, mem_addr); end
        tick;
        cpu_rd = 0;
    endtask

    task automatic test_hold_abort;
        tick;
        cpu_rd = 1; cpu_addr = 32'h80;
        dma_req = 1; dma_we = 0; dma_addr = 32'h400;
        repeat (8) tick;
        dma_req = 0;
        #1;
        checks++; if (cpu_hold !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("FAIL abort_hold got hold=%b gnt=%b want 1 0", cpu_hold, dma_gnt); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL abort_noacc got %b want 00", {mem_read, mem_write}); end
        tick;
        #1;
        checks++; if (cpu_hold !== 1'b0 || starve_cnt !== 4'd0) begin errors++; $display("FAIL abort_exit got hold=%b cnt=%0d want 0 0", cpu_hold, starve_cnt); end
        checks++; if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin errors++; $display("FAIL abort_rvalid got %b want 00", {cpu_rvalid, dma_rvalid}); end
        cpu_rd = 0;
    endtask

    task automatic test_reset_in_hold;
        tick;
        cpu_rd = 1; cpu_addr = 32'hC0;
        dma_req = 1; dma_we = 0; dma_addr = 32'h500;
        repeat (8) tick;
        RST = 1'b1;
        #1;
        checks++; if (cpu_hold !== 1'b1 || dma_gnt !== 1'b1 || mem_read !== 1'b1) begin errors++; $display("FAIL rsthold_pre got hold=%b gnt=%b rd=%b want 1 1 1", cpu_hold, dma_gnt, mem_read); end
        tick;
        RST = 1'b0; dma_req = 0; cpu_rd = 0;
        #1;
        checks++; if (cpu_hold !== 1'b0 || dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rsthold_post got hold=%b drv=%b crv=%b want 0 0 0", cpu_hold, dma_rvalid, cpu_rvalid); end
        checks++; if (starve_cnt !== 4'd0) begin errors++; $display("FAIL rsthold_cnt got %0d want 0", starve_cnt); end
    endtask

    initial begin
        test_reset;
        test_cpu_read;
        test_collision;
        test_starvation;
        test_hold_abort;
        test_reset_in_hold;
        tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
